// File: rtl/if_fetch_pkg.sv
// Shared constants, FSM state encoding and helpers for the instruction-fetch stage.
package if_fetch_pkg;

    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam int unsigned INST_LEN  = 4;   // bytes per instruction

    // Fetch sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        IF_ISS0 = 3'd0,   // issue byte 0 address
        IF_ISS1 = 3'd1,   // capture byte 0, issue byte 1
        IF_ISS2 = 3'd2,   // capture byte 1, issue byte 2
        IF_ISS3 = 3'd3,   // capture byte 2, issue byte 3
        IF_LAST = 3'd4,   // capture byte 3, present instruction
        IF_HOLD = 3'd5    // instruction presented, waiting for consume
    } if_state_e;

    // Byte lane captured while sitting in a given state.
    function automatic logic [1:0] byte_index(input if_state_e s);
        case (s)
            IF_ISS2: byte_index = 2'd1;
            IF_ISS3: byte_index = 2'd2;
            IF_LAST: byte_index = 2'd3;
            default: byte_index = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/if_byte_assembler.sv
// Little-endian byte assembler: captures one memory byte per cycle into the
// selected lane of a 32-bit word. word_o already contains the byte currently on
// byte_i, so the final byte can be forwarded in the same cycle it is captured.
module if_byte_assembler
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,     // capture byte_i into lane idx_i
    input  logic        clr_i,    // discard all captured bytes
    input  logic [1:0]  idx_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o
);

    logic [31:0] buf_q;

    // Merge the incoming byte into its lane on top of the stored bytes.
    always_comb begin
        // NOTE: full default before the partial overwrite keeps this purely combinational (no latch).
        word_o                      = buf_q;
        word_o[{idx_i, 3'b000} +: 8] = byte_i;
    end

    // Byte buffer; clear takes precedence over capture.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the buffer is a handful of flops, not a RAM, so it is reset like any other state.
        if (!rst_n) begin
            buf_q <= ZERO_WORD;
        end else if (clr_i) begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            buf_q <= ZERO_WORD;
        end else if (en_i) begin
            buf_q <= word_o;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: walks the PC, reads four bytes over the 8-bit memory
// port, assembles them little-endian and presents them with a valid/stall
// handshake. Branch/jump redirects restart the fetch at the target.
// Optional feature macro: IF_MISALIGN_CHK_EN (adds inst_misalign_o and reports
// misaligned redirect targets instead of truncating them).
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              dclk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              stall_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic [7:0]        mem_din_i,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_req_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic              inst_misalign_o
`endif
);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
`ifdef IF_MISALIGN_CHK_EN
    logic              misalign_q, misalign_d;
`endif

    logic              cap_en;
    logic              cap_clr;
    logic [1:0]        byte_idx;
    logic [31:0]       asm_word;

    assign byte_idx = byte_index(state_q);

    // Capture control for the byte assembler; a redirect drops in-flight bytes.
    always_comb begin
        cap_en  = DISABLE;
        cap_clr = DISABLE;
        if (rdy) begin
            if (jump_en_i) begin
                cap_clr = ENABLE;
            end else if (state_q inside {IF_ISS1, IF_ISS2, IF_ISS3, IF_LAST}) begin
                cap_en = ENABLE;
            end
        end
    end

    if_byte_assembler u_asm (
        .clk    (dclk),
        .rst_n  (rst),
        .en_i   (cap_en),
        .clr_i  (cap_clr),
        .idx_i  (byte_idx),
        .byte_i (mem_din_i),
        .word_o (asm_word)
    );

    // Next-state logic: redirect first, then the fetch sequence.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_a_d      = mem_a_q;
        mem_req_d    = mem_req_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
`ifdef IF_MISALIGN_CHK_EN
        misalign_d   = misalign_q;
`endif
        if (jump_en_i) begin
            // Redirect wins over completion in LAST and over consume in HOLD.
            inst_valid_d = DISABLE;
            mem_req_d    = DISABLE;
            state_d      = IF_ISS0;
`ifdef IF_MISALIGN_CHK_EN
            pc_d         = jump_addr_i;
            misalign_d   = DISABLE;
            if (jump_addr_i[1:0] != 2'b00) begin
                // Misaligned target: skip the fetch and report it as a null instruction.
                state_d      = IF_HOLD;
                inst_valid_d = ENABLE;
                inst_d       = ZERO_WORD;
                inst_pc_d    = jump_addr_i;
                misalign_d   = ENABLE;
            end
`else
            pc_d         = jump_addr_i & ~ADDR_W'(3);
`endif
        end else begin
            case (state_q)
                IF_ISS0: begin
                    mem_a_d   = pc_q;
                    mem_req_d = ENABLE;
                    state_d   = IF_ISS1;
                end
                IF_ISS1: begin
                    mem_a_d = pc_q + ADDR_W'(1);
                    state_d = IF_ISS2;
                end
                IF_ISS2: begin
                    mem_a_d = pc_q + ADDR_W'(2);
                    state_d = IF_ISS3;
                end
                IF_ISS3: begin
                    mem_a_d = pc_q + ADDR_W'(3);
                    state_d = IF_LAST;
                end
                IF_LAST: begin
                    mem_req_d    = DISABLE;
                    inst_d       = asm_word;
                    inst_pc_d    = pc_q;
                    inst_valid_d = ENABLE;
                    state_d      = IF_HOLD;
                end
                IF_HOLD: begin
                    if (!stall_i) begin
                        inst_valid_d = DISABLE;
                        pc_d         = pc_q + ADDR_W'(INST_LEN);
                        state_d      = IF_ISS0;
`ifdef IF_MISALIGN_CHK_EN
                        misalign_d   = DISABLE;
`endif
                    end
                end
                default: begin
                    state_d = IF_ISS0;
                end
            endcase
        end
    end

    // State and registered outputs; rdy low freezes everything.
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            state_q      <= IF_ISS0;
            pc_q         <= RESET_PC;
            mem_a_q      <= '0;
            mem_req_q    <= DISABLE;
            inst_q       <= ZERO_WORD;
            inst_pc_q    <= '0;
            inst_valid_q <= DISABLE;
`ifdef IF_MISALIGN_CHK_EN
            misalign_q   <= DISABLE;
`endif
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_a_q      <= mem_a_d;
            mem_req_q    <= mem_req_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
`ifdef IF_MISALIGN_CHK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign mem_a_o      = mem_a_q;
    assign mem_req_o    = mem_req_q & rdy;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;
`ifdef IF_MISALIGN_CHK_EN
    assign inst_misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a transaction-level model (cycles since the
// current fetch started, expected PC) checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_if_fetch;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IF_MISALIGN_CHK_EN
    localparam logic [31:0] LAST_JUMP = 32'h40;
`else
    localparam logic [31:0] LAST_JUMP = 32'h43;   // low bits must be dropped
`endif

    logic        dclk        = 1'b0;
    logic        rst         = 1'b0;
    logic        rdy         = 1'b1;
    logic        stall_i     = 1'b1;
    logic        jump_en_i   = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic [7:0]  mem_din_i;
    logic [31:0] mem_a_o;
    logic        mem_req_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
`ifdef IF_MISALIGN_CHK_EN
    logic        inst_misalign_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:511];

    if_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .dclk         (dclk),
        .rst          (rst),
        .rdy          (rdy),
        .stall_i      (stall_i),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .mem_din_i    (mem_din_i),
        .mem_a_o      (mem_a_o),
        .mem_req_o    (mem_req_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .inst_misalign_o (inst_misalign_o)
`endif
    );

    always #5 dclk = ~dclk;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem[a[8:0]];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_rd(a + 32'd3), mem_rd(a + 32'd2), mem_rd(a + 32'd1), mem_rd(a)};
    endfunction

    // Memory: data for the presented address is available before the next edge.
    always_comb mem_din_i = mem_rd(mem_a_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t = active cycles since the current fetch began (5 = presented).
    int          t      = 0;
    logic [31:0] exp_pc = RESET_PC;
    bit          mis    = 1'b0;

    always @(posedge dclk or negedge rst) begin
        if (!rst) begin
            t      = 0;
            exp_pc = RESET_PC;
            mis    = 1'b0;
        end else if (rdy) begin
            if (jump_en_i) begin
`ifdef IF_MISALIGN_CHK_EN
                exp_pc = jump_addr_i;
                mis    = (jump_addr_i[1:0] != 2'b00);
                t      = mis ? 5 : 0;
`else
                exp_pc = {jump_addr_i[31:2], 2'b00};
                t      = 0;
`endif
            end else if (t == 5) begin
                if (!stall_i) begin
                    exp_pc = exp_pc + 32'd4;
                    t      = 0;
                    mis    = 1'b0;
                end
            end else begin
                t = t + 1;
            end
        end
    end

    // Per-cycle comparison against the model, just after each rising edge.
    always @(posedge dclk) begin
        #1;
        if (!rst) begin
            check("rst_valid", 32'(inst_valid_o), 32'h0);
            check("rst_req",   32'(mem_req_o),    32'h0);
            check("rst_inst",  inst_o,            32'h0);
            check("rst_pc",    inst_pc_o,         32'h0);
            check("rst_addr",  mem_a_o,           32'h0);
        end else begin
            check("m_valid", 32'(inst_valid_o), 32'(t == 5));
            check("m_req",   32'(mem_req_o),    32'(rdy && t >= 1 && t <= 4));
            if (t >= 1 && t <= 4)
                check("m_addr", mem_a_o, exp_pc + 32'(t - 1));
            if (t == 5) begin
                check("m_inst", inst_o,    mis ? 32'h0 : mem_word(exp_pc));
                check("m_pc",   inst_pc_o, exp_pc);
            end
`ifdef IF_MISALIGN_CHK_EN
            check("m_misalign", 32'(inst_misalign_o), 32'(mis));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge dclk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'h00;

        // Reset values
        tick(2);
        check("reset_valid", 32'(inst_valid_o), 32'h0);
        check("reset_inst",  inst_o,            32'h0);
        rst = 1'b1;

        // First fetch: address sequence 0..3, valid on the 5th edge
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("seq_addr", mem_a_o, 32'(k));
            check("seq_req",  32'(mem_req_o), 32'h1);
        end
        tick(1);
        check("first_valid", 32'(inst_valid_o), 32'h1);
        check("first_inst",  inst_o,    32'h00A0_0513);
        check("first_pc",    inst_pc_o, 32'h0);

        // Stall in HOLD for 3 cycles
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("stall_valid", 32'(inst_valid_o), 32'h1);
            check("stall_inst",  inst_o,    32'h00A0_0513);
            check("stall_pc",    inst_pc_o, 32'h0);
            check("stall_req",   32'(mem_req_o), 32'h0);
        end
        stall_i = 1'b0;
        tick(1);
        check("consume_valid", 32'(inst_valid_o), 32'h0);
        stall_i = 1'b1;
        tick(1);
        check("next_addr", mem_a_o, 32'h4);

        // Redirect while in ISS2
        tick(1);
        jump_en_i = 1'b1; jump_addr_i = 32'h100;
        tick(1);
        jump_en_i = 1'b0;
        check("jmp_iss2_valid", 32'(inst_valid_o), 32'h0);
        tick(1);
        check("jmp_iss2_addr", mem_a_o, 32'h100);
        tick(3);
        check("jmp_iss2_wait", 32'(inst_valid_o), 32'h0);
        tick(1);
        check("jmp_iss2_valid2", 32'(inst_valid_o), 32'h1);
        check("jmp_iss2_pc",     inst_pc_o, 32'h100);
        check("jmp_iss2_inst",   inst_o,    32'h1811_0A03);

        // Redirect and consume together in HOLD: redirect wins
        stall_i = 1'b0; jump_en_i = 1'b1; jump_addr_i = 32'h1F0;
        tick(1);
        jump_en_i = 1'b0; stall_i = 1'b1;
        check("jmp_hold_valid", 32'(inst_valid_o), 32'h0);
        tick(1);
        check("jmp_hold_addr", mem_a_o, 32'h1F0);
        tick(4);
        check("jmp_hold_pc", inst_pc_o, 32'h1F0);

        // Address wrap at the top of memory
        jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
        tick(1);
        jump_en_i = 1'b0;
        tick(1);
        check("wrap_addr0", mem_a_o, 32'hFFFF_FFFC);
        tick(4);
        check("wrap_pc", inst_pc_o, 32'hFFFF_FFFC);
        stall_i = 1'b0;
        tick(1);
        stall_i = 1'b1;
        tick(1);
        check("wrap_next", mem_a_o, 32'h0);

        // Redirect in LAST: the instruction at 0 is never presented
        tick(3);
        jump_en_i = 1'b1; jump_addr_i = LAST_JUMP;
        tick(1);
        jump_en_i = 1'b0;
        check("jmp_last_valid", 32'(inst_valid_o), 32'h0);
        tick(1);
        check("jmp_last_addr", mem_a_o, 32'h40);
        tick(3);
        check("jmp_last_wait", 32'(inst_valid_o), 32'h0);
        tick(1);
        check("jmp_last_pc",   inst_pc_o, 32'h40);
        check("jmp_last_inst", inst_o,    32'hD8D1_CAC3);

        // Async reset in LAST
        stall_i = 1'b0;
        tick(1);
        stall_i = 1'b1;
        tick(4);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 32'(inst_valid_o), 32'h0);
        check("arst_inst",  inst_o,    32'h0);
        check("arst_pc",    inst_pc_o, 32'h0);
        check("arst_addr",  mem_a_o,   32'h0);
        tick(2);
        rst = 1'b1;

        // Restart at RESET_PC, then freeze with rdy=0 for 4 cycles in ISS1
        tick(1);
        check("restart_addr", mem_a_o, 32'h0);
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("frz_addr",  mem_a_o, 32'h0);
            check("frz_req",   32'(mem_req_o), 32'h0);
            check("frz_valid", 32'(inst_valid_o), 32'h0);
        end
        rdy = 1'b1;
        tick(3);
        check("frz_wait", 32'(inst_valid_o), 32'h0);
        tick(1);
        check("frz_valid2", 32'(inst_valid_o), 32'h1);
        check("frz_inst",   inst_o, 32'h00A0_0513);

`ifdef IF_MISALIGN_CHK_EN
        // Misaligned redirect reported without fetching
        jump_en_i = 1'b1; jump_addr_i = 32'h102;
        tick(1);
        jump_en_i = 1'b0;
        check("mis_valid", 32'(inst_valid_o), 32'h1);
        check("mis_flag",  32'(inst_misalign_o), 32'h1);
        check("mis_inst",  inst_o,    32'h0);
        check("mis_pc",    inst_pc_o, 32'h102);
        stall_i = 1'b0;
        tick(1);
        stall_i = 1'b1;
        check("mis_clr", 32'(inst_misalign_o), 32'h0);
`endif

        tick(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage: the producer feeding the IF/ID pipeline buffer.
- Holds the PC and reads 4 consecutive bytes from the 8-bit unified memory port.
- Assembles them little-endian into a 32-bit instruction and presents it with a valid/stall handshake.
- Accepts branch/jump redirects from later stages; sits between the memory controller and IF/ID.

Parameters:
- ADDR_W, 32, width of PC and memory byte address.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- dclk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- rdy  input  1  global ready; low freezes all state
- stall_i  input  1  downstream cannot accept; holds current instruction
- jump_en_i  input  1  redirect request
- jump_addr_i  input  ADDR_W  redirect target
- mem_din_i  input  8  byte returned by memory, 1 cycle after address
- mem_a_o  output  ADDR_W  byte read address
- mem_req_o  output  1  read request this cycle
- inst_o  output  32  assembled instruction
- inst_pc_o  output  ADDR_W  PC of inst_o
- inst_valid_o  output  1  inst_o/inst_pc_o valid

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=ISS0, inst_o=0, inst_pc_o=0, inst_valid_o=0, mem_req_o=0, mem_a_o=0.
- Memory latency: address registered at cycle n, mem_din_i valid at n+1. Requests are pipelined, one byte per cycle.
- FSM states: ISS0, ISS1, ISS2, ISS3, LAST, HOLD.
  - ISS0: mem_a_o=pc, mem_req_o=1; go to ISS1.
  - ISS1 / ISS2 / ISS3: capture previous byte into buf[7:0] / [15:8] / [23:16]; issue pc+1 / pc+2 / pc+3.
  - LAST: capture byte into [31:24], mem_req_o=0. Next edge: inst_o=buf, inst_pc_o=pc, inst_valid_o=1, state=HOLD.
  - HOLD with stall_i=0: consume. inst_valid_o=0, pc=pc+4, state=ISS0.
  - HOLD with stall_i=1: outputs held unchanged.
- Latency: fixed 5 cycles from entering ISS0 to inst_valid_o=1. Unstalled throughput is one instruction per 6 cycles.
- Address arithmetic: pc+k and pc+4 are modulo 2^ADDR_W and wrap silently at the top of memory.
- Redirect (jump_en_i=1, rdy=1), in any state:
  - pc=jump_addr_i, inst_valid_o=0, state=ISS0.
  - Captured bytes and in-flight data are discarded.
  - jump_addr_i[1:0] forced to 0.
- Redirect precedence:
  - Over consume in HOLD.
  - Over completion in LAST: the instruction is not presented.
- rdy=0: all registers frozen, mem_req_o=0. Memory controller shares rdy and holds mem_din_i stable, so the fetch resumes seamlessly when rdy=1.
- Async reset mid-fetch: immediate return to reset values; no partial instruction is ever presented.

Optional Feature:
- Macro IF_MISALIGN_CHK_EN.
- Defined:
  - Adds output inst_misalign_o (1 bit, reset 0).
  - A redirect with jump_addr_i[1:0]!=0 keeps the full address, skips the fetch and goes to HOLD.
  - In HOLD it presents inst_valid_o=1, inst_o=0, inst_pc_o=jump_addr_i, inst_misalign_o=1.
  - Cleared on consume or on the next redirect.
- Undefined: port absent; low two bits forced to 0.

Decomposition:
- macro.vh holds `Enable, `Disable, `ZeroWord, the FSM state encodings (`IF_ISS0..`IF_HOLD, 3 bits) and `InstLen (4).
- One sub-module, if_byte_assembler: shift/capture register taking mem_din_i, a byte index and a clear. It outputs the 32-bit word.
- PC and FSM stay in if_fetch.

Test Plan:
- Reset then run; memory bytes 0..3 = 13,05,A0,00, stall_i=0 -> cycle 5: inst_valid_o=1, inst_o=32'h00A00513, inst_pc_o=0; mem_a_o sequence 0,1,2,3 then 4.
- stall_i=1 for 3 cycles in HOLD -> inst_o/inst_pc_o/inst_valid_o unchanged, mem_req_o=0. Release -> next fetch issues address 4.
- jump_en_i pulse in ISS2 with jump_addr_i=32'h100 -> inst_valid_o stays 0, next mem_a_o=0x100, valid 5 cycles later with inst_pc_o=0x100.
- jump_en_i=1 and stall_i=0 in HOLD simultaneously -> redirect wins, pc=jump target, not pc+4.
- rdy=0 for 4 cycles during ISS1 -> all outputs frozen; after resume inst_o identical to the unstalled run, latency +4.
- rst asserted mid-LAST -> inst_valid_o=0 immediately. After release, fetch restarts at RESET_PC. With IF_MISALIGN_CHK_EN, a jump to 0x102 yields inst_misalign_o=1 and inst_pc_o=0x102.
